// File: rtl/i2c_reg_pkg.sv
// rtl/i2c_reg_pkg.sv - shared types and constants for the I2C register target
//
// Purpose: state encoding of the target FSM, default 7-bit bus address and
// the bus-level ACK/NACK values seen on SDA.
package i2c_reg_pkg;

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK, WHI, WHI_ACK,
        WLO, WLO_ACK, RHI, RHI_MACK, RLO, RLO_MACK, WAIT_STOP
    } state_t;

    // 0x78 = write byte, 0x79 = read byte
    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h3C;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizers and bus event detection
//
// Purpose: brings scl_i/sda_i into the clk domain and produces one-clk event
// pulses. All outputs are registered, so pin-to-pulse latency is
// SYNC_STAGES+1 clk. sda_val is the SDA level aligned with the pulses.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   scl_i, sda_i        raw bus pins
//   scl_rise, scl_fall  one-clk SCL edge pulses
//   start_det, stop_det one-clk START / STOP pulses
//   sda_val             synchronized SDA, aligned with the pulses
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_val
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s, sda_s;
    logic                   scl_d, sda_d;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Flops reset to the idle-bus level so no event fires out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_val   <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d     <= scl_s;
            sda_d     <= sda_s;
            scl_rise  <= scl_s & ~scl_d;
            scl_fall  <= ~scl_s & scl_d;
            start_det <= scl_s & scl_d & sda_d & ~sda_s;
            stop_det  <= scl_s & scl_d & ~sda_d & sda_s;
            sda_val   <= sda_s;
        end
    end

endmodule

// File: rtl/i2c_reg_slave.sv
// rtl/i2c_reg_slave.sv - I2C target for 16-bit address / 16-bit data registers
//
// Purpose: decodes I2C register transactions (dev byte, addr hi/lo, data
// hi/lo words with auto-increment) into a simple register-file port.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   scl_i, sda_i    bus inputs (no clock stretching)
//   sda_oe          1 = pull SDA low (open drain)
//   reg_addr        register pointer
//   reg_wdata       write data, valid with reg_we
//   reg_we, reg_re  one-clk write / read strobes
//   reg_rdata       read data, sampled 2 clk after reg_re
//   busy            addressed transaction in progress
module i2c_reg_slave
    import i2c_reg_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [15:0] reg_rdata,
    output logic        busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_val;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_val   (sda_val)
    );

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [7:0]  rx, rx_nxt;
    logic [7:0]  addr_hi, addr_hi_nxt;
    logic [7:0]  wd_hi, wd_hi_nxt;
    logic [15:0] tx, tx_nxt;
    logic        mack, mack_nxt;
    logic        re_d1;
    logic        sda_oe_nxt, busy_nxt, reg_we_nxt, reg_re_nxt;
    logic [15:0] reg_addr_nxt, reg_wdata_nxt;
    logic        byte_done, dev_match;

    assign byte_done = (cnt == 4'd8);
    assign dev_match = (rx[7:1] == DEV_ADDR);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rx        <= '0;
            addr_hi   <= '0;
            wd_hi     <= '0;
            tx        <= '0;
            mack      <= NACK;
            re_d1     <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rx        <= rx_nxt;
            addr_hi   <= addr_hi_nxt;
            wd_hi     <= wd_hi_nxt;
            tx        <= tx_nxt;
            mack      <= mack_nxt;
            re_d1     <= reg_re;
            sda_oe    <= sda_oe_nxt;
            busy      <= busy_nxt;
            reg_addr  <= reg_addr_nxt;
            reg_wdata <= reg_wdata_nxt;
            reg_we    <= reg_we_nxt;
            reg_re    <= reg_re_nxt;
        end
    end

    // Next state: byte/ACK boundaries are all taken on SCL falls.
    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = DEV;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else if (scl_fall) begin
            case (state)
                DEV:      if (byte_done) state_nxt = dev_match ? DEV_ACK : WAIT_STOP;
                DEV_ACK:  state_nxt = rx[0] ? RHI : AHI;
                AHI:      if (byte_done) state_nxt = AHI_ACK;
                AHI_ACK:  state_nxt = ALO;
                ALO:      if (byte_done) state_nxt = ALO_ACK;
                ALO_ACK:  state_nxt = WHI;
                WHI:      if (byte_done) state_nxt = WHI_ACK;
                WHI_ACK:  state_nxt = WLO;
                WLO:      if (byte_done) state_nxt = WLO_ACK;
                WLO_ACK:  state_nxt = WHI;
                RHI:      if (byte_done) state_nxt = RHI_MACK;
                RHI_MACK: state_nxt = (mack == ACK) ? RLO : WAIT_STOP;
                RLO:      if (byte_done) state_nxt = RLO_MACK;
                RLO_MACK: state_nxt = (mack == ACK) ? RHI : WAIT_STOP;
                default:  state_nxt = state;
            endcase
        end
    end

    // Outputs and datapath next values
    always_comb begin
        cnt_nxt       = cnt;
        rx_nxt        = rx;
        addr_hi_nxt   = addr_hi;
        wd_hi_nxt     = wd_hi;
        tx_nxt        = tx;
        mack_nxt      = mack;
        sda_oe_nxt    = sda_oe;
        busy_nxt      = busy;
        reg_addr_nxt  = reg_addr;
        reg_wdata_nxt = reg_wdata;
        reg_we_nxt    = 1'b0;
        reg_re_nxt    = 1'b0;
        if (start_det) begin
            cnt_nxt    = '0;
            sda_oe_nxt = 1'b0;
        end else if (stop_det) begin
            cnt_nxt    = '0;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else begin
            if (re_d1)
                tx_nxt = reg_rdata;
            if (scl_rise) begin
                case (state)
                    DEV, AHI, ALO, WHI, WLO: begin
                        rx_nxt  = {rx[6:0], sda_val};
                        cnt_nxt = cnt + 4'd1;
                        if (state == WLO && cnt == 4'd7) begin
                            reg_wdata_nxt = {wd_hi, rx[6:0], sda_val};
                            reg_we_nxt    = 1'b1;
                        end
                    end
                    RHI, RLO: cnt_nxt = cnt + 4'd1;
                    RHI_MACK: mack_nxt = sda_val;
                    // Fetch the next word on the master's ACK rise so the
                    // data is in tx before the fall that must drive bit 15.
                    RLO_MACK: begin
                        mack_nxt     = sda_val;
                        reg_addr_nxt = reg_addr + 16'd1;
                        reg_re_nxt   = (sda_val == ACK);
                    end
                    default: ;
                endcase
            end
            if (scl_fall) begin
                case (state)
                    DEV: if (byte_done) begin
                        cnt_nxt    = '0;
                        sda_oe_nxt = dev_match;
                        busy_nxt   = dev_match;
                        reg_re_nxt = dev_match & rx[0];
                    end
                    AHI: if (byte_done) begin
                        cnt_nxt     = '0;
                        sda_oe_nxt  = 1'b1;
                        addr_hi_nxt = rx;
                    end
                    ALO: if (byte_done) begin
                        cnt_nxt      = '0;
                        sda_oe_nxt   = 1'b1;
                        reg_addr_nxt = {addr_hi, rx};
                    end
                    WHI: if (byte_done) begin
                        cnt_nxt    = '0;
                        sda_oe_nxt = 1'b1;
                        wd_hi_nxt  = rx;
                    end
                    WLO: if (byte_done) begin
                        cnt_nxt    = '0;
                        sda_oe_nxt = 1'b1;
                    end
                    // rx still holds the dev byte here, so rx[0] is R/W.
                    DEV_ACK: begin
                        if (rx[0]) begin
                            sda_oe_nxt = ~tx[15];
                            tx_nxt     = {tx[14:0], 1'b0};
                        end else begin
                            sda_oe_nxt = 1'b0;
                        end
                    end
                    AHI_ACK, ALO_ACK, WHI_ACK: sda_oe_nxt = 1'b0;
                    WLO_ACK: begin
                        sda_oe_nxt   = 1'b0;
                        reg_addr_nxt = reg_addr + 16'd1;
                    end
                    RHI, RLO: begin
                        if (byte_done) begin
                            cnt_nxt    = '0;
                            sda_oe_nxt = 1'b0;
                        end else begin
                            sda_oe_nxt = ~tx[15];
                            tx_nxt     = {tx[14:0], 1'b0};
                        end
                    end
                    RHI_MACK, RLO_MACK: begin
                        if (mack == ACK) begin
                            sda_oe_nxt = ~tx[15];
                            tx_nxt     = {tx[14:0], 1'b0};
                        end else begin
                            sda_oe_nxt = 1'b0;
                            busy_nxt   = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
